// File: rtl/mult_batch_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mult_batch_sequencer
//   Runs one multiply/readback batch against the multiplier and its 64-deep
//   result memory.
//   1. Offers LEN operand beats on EN_mult and counts the ones the multiplier
//      accepts.
//   2. Waits DRAIN_CYC cycles so the pipeline can finish writing.
//   3. Pulses EN_blockRead.
//   4. Forwards the first LEN readback beats to the host as an indexed stream.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, len      batch request (sampled in IDLE only), operand count 1..64
//   abort           synchronous cancel of the running batch
//   busy            high whenever the sequencer is not idle
//   done            one-cycle completion pulse (normal, timeout, illegal len)
//   err             sticky error (illegal len / read timeout), cleared on start
//   op_idx          index of the operand currently offered
//   EN_mult         operand valid to multiplier; RDY_mult = accept
//   EN_blockRead    one-cycle pulse starting the memory readback
//   VALID_memVal    readback beat valid; memVal_data = readback data
//   out_valid       result beat to host (registered)
//   out_idx         index of the result beat
//   out_data        result data
// -----------------------------------------------------------------------------
module mult_batch_sequencer #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 6,
    parameter int DRAIN_CYC = 4,
    parameter int TIMEOUT   = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] op_idx,
    output logic              EN_mult,
    input  logic              RDY_mult,
    output logic              EN_blockRead,
    input  logic              VALID_memVal,
    input  logic [WIDTH-1:0]  memVal_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_idx,
    output logic [WIDTH-1:0]  out_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;               // holds 0..DEPTH without wrap
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  len_reg;
    logic [CNT_W-1:0]  issue_cnt_reg;
    logic [CNT_W-1:0]  rcv_cnt_reg;
    logic [DRN_W-1:0]  drain_cnt_reg;
    logic [TMO_W-1:0]  idle_cnt_reg;
    logic              first_read_reg;
    logic              err_reg;
    logic              bad_start_reg;
    logic              out_valid_reg;
    logic [ADDR_W-1:0] out_idx_reg;
    logic [WIDTH-1:0]  out_data_reg;

    // Decoded events for the current cycle
    logic len_ok;
    logic start_ok;
    logic start_bad;
    logic accept;
    logic last_accept;
    logic drain_end;
    logic beat_take;
    logic last_beat;
    logic timed_out;
    logic active_abort;

    always_comb begin
        active_abort = abort && (state_reg != ST_IDLE);
        len_ok       = (len != '0) && (len <= CNT_W'(DEPTH));
        // abort wins over a simultaneous start, even in IDLE
        start_ok     = (state_reg == ST_IDLE) && start && !abort && len_ok;
        start_bad    = (state_reg == ST_IDLE) && start && !abort && !len_ok;
        accept       = (state_reg == ST_MULT) && !abort && RDY_mult;
        last_accept  = accept && (issue_cnt_reg == len_reg - CNT_W'(1));
        drain_end    = (drain_cnt_reg == DRN_W'(DRAIN_CYC - 1));
        // Beats past len (the block read is always full depth) are never taken
        beat_take    = (state_reg == ST_READ) && !abort && VALID_memVal
                       && (rcv_cnt_reg < len_reg);
        last_beat    = beat_take && (rcv_cnt_reg == len_reg - CNT_W'(1));
        timed_out    = (state_reg == ST_READ) && !abort && !VALID_memVal
                       && (idle_cnt_reg == TMO_W'(TIMEOUT - 1));
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        if (active_abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (start_ok)                state_next = ST_MULT;
                ST_MULT:  if (last_accept)             state_next = ST_DRAIN;
                ST_DRAIN: if (drain_end)               state_next = ST_READ;
                ST_READ:  if (last_beat || timed_out)  state_next = ST_DONE;
                ST_DONE:                               state_next = ST_IDLE;
                default:                               state_next = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy         = (state_reg != ST_IDLE);
        // Illegal-len requests complete from IDLE via bad_start_reg
        done         = ((state_reg == ST_DONE) && !abort) || bad_start_reg;
        err          = err_reg;
        EN_mult      = (state_reg == ST_MULT) && !abort;
        op_idx       = (state_reg == ST_MULT) ? issue_cnt_reg[ADDR_W-1:0] : '0;
        EN_blockRead = (state_reg == ST_READ) && first_read_reg && !abort;
        out_valid    = out_valid_reg && !active_abort;
        out_idx      = out_idx_reg;
        out_data     = out_data_reg;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg        <= '0;
            issue_cnt_reg  <= '0;
            rcv_cnt_reg    <= '0;
            drain_cnt_reg  <= '0;
            idle_cnt_reg   <= '0;
            first_read_reg <= 1'b0;
            err_reg        <= 1'b0;
            bad_start_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_idx_reg    <= '0;
            out_data_reg   <= '0;
        end else begin
            bad_start_reg <= start_bad;
            out_valid_reg <= beat_take;

            if (start_ok) begin
                len_reg       <= len;
                issue_cnt_reg <= '0;
                rcv_cnt_reg   <= '0;
                err_reg       <= 1'b0;
            end else begin
                if (accept) begin
                    issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                end
                if (beat_take) begin
                    rcv_cnt_reg <= rcv_cnt_reg + CNT_W'(1);
                end
                if (start_bad || timed_out) begin
                    err_reg <= 1'b1;
                end
            end

            if (beat_take) begin
                out_idx_reg  <= rcv_cnt_reg[ADDR_W-1:0];
                out_data_reg <= memVal_data;
            end

            if ((state_reg == ST_DRAIN) && !drain_end) begin
                drain_cnt_reg <= drain_cnt_reg + DRN_W'(1);
            end else begin
                drain_cnt_reg <= '0;
            end

            // Consecutive READ cycles without a beat; any beat restarts it
            if ((state_reg == ST_READ) && !VALID_memVal) begin
                idle_cnt_reg <= idle_cnt_reg + TMO_W'(1);
            end else begin
                idle_cnt_reg <= '0;
            end

            // High in the cycle after DRAIN, i.e. only on the first READ cycle
            first_read_reg <= (state_reg == ST_DRAIN);
        end
    end

endmodule

// File: tb/tb_mult_batch_sequencer.sv
`timescale 1ns/1ps
module tb_mult_batch_sequencer;

    localparam int WIDTH     = 32;
    localparam int ADDR_W    = 6;
    localparam int DRAIN_CYC = 4;
    localparam int TIMEOUT   = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] op_idx;
    logic              EN_mult;
    logic              RDY_mult;
    logic              EN_blockRead;
    logic              VALID_memVal;
    logic [WIDTH-1:0]  memVal_data;
    logic              out_valid;
    logic [ADDR_W-1:0] out_idx;
    logic [WIDTH-1:0]  out_data;

    mult_batch_sequencer #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .busy(busy), .done(done), .err(err), .op_idx(op_idx),
        .EN_mult(EN_mult), .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Operand source: a = index, b = index*k + seed; result is a*b mod 2^WIDTH
    function automatic logic [WIDTH-1:0] product(input int i, input int unsigned km,
                                                 input int unsigned sd);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = WIDTH'(i);
        b = WIDTH'(i * km + sd);
        return a * b;
    endfunction

    // ------------------------------------------------ multiplier/memory model
    int          cyc = 0;
    int          acc_cnt = 0;
    int          en_cycles = 0;
    int          last_acc_cyc = 0;
    int          blk_cyc = 0;
    int          blk_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rdy_mode = 0;     // 0 always ready, 1 toggle, 2 random
    bit          rdy_phase = 1'b0;
    bit          gaps = 1'b0;
    bit          mute = 1'b0;
    int unsigned k_mul = 1;
    int unsigned seed = 0;
    logic [WIDTH-1:0] mem [64];
    int          stream_ptr = 0;
    bit          stream_on = 1'b0;

    always @(negedge clk) begin
        cyc++;
        rdy_phase = ~rdy_phase;
        case (rdy_mode)
            0:       RDY_mult = 1'b1;
            1:       RDY_mult = rdy_phase;
            default: RDY_mult = ($urandom_range(0, 2) != 0);
        endcase
        if (stream_on && (!gaps || $urandom_range(0, 2) != 0)) begin
            VALID_memVal = 1'b1;
            memVal_data  = mem[stream_ptr];
            stream_ptr++;
            if (stream_ptr == 64) stream_on = 1'b0;
        end else begin
            VALID_memVal = 1'b0;
            memVal_data  = $urandom;
        end
        if (rst === 1'b0) begin
            if (EN_mult === 1'b1) begin
                en_cycles++;
                if (RDY_mult) begin
                    chk("op_idx_order", op_idx, acc_cnt);
                    mem[op_idx] = product(int'(op_idx), k_mul, seed);
                    acc_cnt++;
                    last_acc_cyc = cyc;
                end
            end
            if (EN_blockRead === 1'b1) begin
                blk_cnt++;
                blk_cyc = cyc;
                if (!mute) begin
                    stream_on  = 1'b1;
                    stream_ptr = 0;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ------------------------------------------------------- result monitor
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_idx", out_idx, mon_e.idx);
                chk("out_data", out_data, mon_e.data);
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    int d0;
    int n;

    task automatic prep_batch(input int L, input int rmode, input bit gp, input bit mt,
                              input int unsigned km, input int unsigned sd);
        beat_t b;
        rdy_mode = rmode;
        gaps     = gp;
        mute     = mt;
        k_mul    = km;
        seed     = sd;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        acc_cnt   = 0;
        en_cycles = 0;
        blk_cnt   = 0;
        d0        = done_cnt;
        if (L >= 1 && L <= 64 && !mt) begin
            for (int i = 0; i < L; i++) begin
                b.idx  = i;
                b.data = product(i, km, sd);
                exp_q.push_back(b);
            end
        end
        start = 1'b1;
        len   = L[ADDR_W:0];
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_start", busy, (L >= 1 && L <= 64));
        if (L >= 1 && L <= 64) chk("err_cleared_on_start", err, 0);
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        while (stream_on && k < 400) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic finish_batch(input int L, input bit mt);
        bit legal;
        legal = (L >= 1 && L <= 64);
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_seen", done_cnt - d0, 1);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("accepts", acc_cnt, legal ? L : 0);
        chk("blockread_pulses", blk_cnt, legal ? 1 : 0);
        if (!legal) chk("en_mult_cycles", en_cycles, 0);
        if (legal) chk("drain_gap", blk_cyc - last_acc_cyc, DRAIN_CYC + 1);
        if (legal && mt) chk("timeout_gap", done_cyc - blk_cyc, TIMEOUT);
        chk("err", err, (!legal || mt));
        chk("results_outstanding", exp_q.size(), 0);
        wait_quiet();
        chk("done_pulses_total", done_cnt - d0, 1);
        $display("batch len=%0d rdy_mode=%0d gaps=%0b mute=%0b accepts=%0d err=%0b",
                 L, rdy_mode, gaps, mute, acc_cnt, err);
    endtask

    task automatic run_batch(input int L, input int rmode, input bit gp, input bit mt,
                             input int unsigned km, input int unsigned sd);
        prep_batch(L, rmode, gp, mt, km, sd);
        finish_batch(L, mt);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_op_idx"}, op_idx, 0);
        chk({tag, "_EN_mult"}, EN_mult, 0);
        chk({tag, "_EN_blockRead"}, EN_blockRead, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    int a0;
    int e0;

    initial begin
        rst          = 1'b1;
        start        = 1'b1;     // must be ignored while in reset
        len          = 7'd5;
        abort        = 1'b0;
        RDY_mult     = 1'b0;
        VALID_memVal = 1'b0;
        memVal_data  = '0;

        // T1: reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("start_during_reset_ignored", busy, 0);
        $display("reset sequence complete");

        // T2: full 64-deep batch, a = b = index
        run_batch(64, 0, 1'b0, 1'b0, 1, 0);
        // T3: backpressure
        run_batch(8, 1, 1'b0, 1'b0, 7, 3);
        // T4: short batch, remaining memory beats dropped
        run_batch(5, 0, 1'b0, 1'b0, 13, 1);
        // T5: illegal lengths, then read timeout
        run_batch(0, 0, 1'b0, 1'b0, 1, 0);
        run_batch(65, 0, 1'b0, 1'b0, 1, 0);
        run_batch(4, 0, 1'b0, 1'b1, 2, 9);

        // T6a: abort on the 10th operand beat
        prep_batch(20, 0, 1'b0, 1'b0, 3, 7);
        n = 0;
        while (acc_cnt < 9 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("abort_at_beat10_op_idx", op_idx, 9);
        abort = 1'b1;
        #1;
        chk("en_mult_in_abort_cycle", EN_mult, 0);
        a0 = acc_cnt;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        chk("busy_after_abort", busy, 0);
        chk("no_accept_in_abort_cycle", acc_cnt, a0);
        e0 = en_cycles;
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_cnt - d0, 0);
        chk("no_en_mult_after_abort", en_cycles - e0, 0);
        $display("abort during MULT at op_idx=9");
        run_batch(3, 0, 1'b0, 1'b0, 5, 2);

        // T6b: reset in the middle of READ
        prep_batch(16, 0, 1'b1, 1'b0, 5, 11);
        n = 0;
        while ((blk_cnt == 0 || exp_q.size() > 10) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("reached_read_before_rst", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("mid_read_reset");
        rst = 1'b0;
        wait_quiet();
        chk("no_done_after_rst", done_cnt - d0, 0);
        $display("reset during READ");
        run_batch(3, 0, 1'b0, 1'b0, 9, 4);

        // Randomized batches
        for (int t = 0; t < 6; t++) begin
            run_batch($urandom_range(1, 64), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      1'b0, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
